// File: rtl/text_display_pkg.sv
// Shared text-display constants: screen geometry, tile addressing and ASCII codes.
// Also carries the state encoding of the tile text writer FSM.
package text_display_pkg;

  localparam int DISP_WIDTH  = 1280;
  localparam int DISP_HEIGHT = 720;
  localparam int TILE_WIDTH  = 8;
  localparam int TILE_HEIGHT = 16;

  localparam int COLS       = DISP_WIDTH / TILE_WIDTH;
  localparam int ROWS       = DISP_HEIGHT / TILE_HEIGHT;
  localparam int COL_BITS   = 8;
  localparam int ROW_BITS   = 6;
  localparam int ADDR_WIDTH = ROW_BITS + COL_BITS;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ROW_CLR,
    ST_SCR_CLR
  } wr_state_e;

endpackage

// File: rtl/tile_clear_sequencer.sv
// Row/column sweep counter for tile clears: one row, or the full screen.
// Ports: start_i/full_i/row_i load a sweep, step_i advances, row_o/col_o = position to issue, last_o = issued position is final.
module tile_clear_sequencer
  import text_display_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                full_i,
  input  logic                step_i,
  input  logic [ROW_BITS-1:0] row_i,
  output logic [ROW_BITS-1:0] row_o,
  output logic [COL_BITS-1:0] col_o,
  output logic                last_o
);

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                full_q, full_d;

  // row_q/col_q hold the position most recently issued to the BRAM
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    full_d = full_q;
    if (start_i) begin
      full_d = full_i;
      row_d  = full_i ? '0 : row_i;
      col_d  = '0;
    end else if (step_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q  <= '0;
      col_q  <= '0;
      full_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      full_q <= full_d;
    end
  end

  assign row_o  = row_d;
  assign col_o  = col_d;
  assign last_o = (col_q == COL_LAST) && (!full_q || row_q == ROW_LAST);

endmodule

// File: rtl/tile_text_writer.sv
// ASCII stream to tile BRAM port-A writer with cursor, CR/LF/BS/FF and row/screen clears.
// Ports: char_valid/char_data/char_ready in, bram_we/addr/data out, cursor_col/row and busy status.
module tile_text_writer
  import text_display_pkg::*;
(
  input  logic                  clk_75mhz,
  input  logic                  rst_sync,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [7:0]            bram_data,
  output logic [COL_BITS-1:0]   cursor_col,
  output logic [ROW_BITS-1:0]   cursor_row,
  output logic                  busy
);

  wr_state_e             state_q;
  logic [COL_BITS-1:0]   col_q;
  logic [ROW_BITS-1:0]   row_q;
  logic                  wrap_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            data_q;

  logic                  accept;
  logic                  is_print, is_cr, is_lf, is_bs, is_ff;
  logic [ROW_BITS-1:0]   row_adv;

  logic                  seq_start, seq_full, seq_step, seq_last;
  logic [ROW_BITS-1:0]   seq_row, seq_row_nx;
  logic [COL_BITS-1:0]   seq_col_nx;

  assign accept   = char_valid && (state_q == ST_IDLE);
  assign is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign is_cr    = (char_data == CHAR_CR);
  assign is_lf    = (char_data == CHAR_LF);
  assign is_bs    = (char_data == CHAR_BS);
  assign is_ff    = (char_data == CHAR_FF);
  assign row_adv  = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

  // Clears are loaded on the edge that issues their first write
  always_comb begin
    seq_start = 1'b0;
    seq_full  = 1'b0;
    seq_step  = 1'b0;
    seq_row   = row_adv;
    unique case (state_q)
      ST_IDLE: begin
        seq_start = accept && (is_lf || is_ff);
        seq_full  = is_ff;
      end
      ST_WRITE: begin
        seq_start = wrap_q;
        seq_row   = row_q;
      end
      default: seq_step = !seq_last;
    endcase
  end

  tile_clear_sequencer u_seq (
    .clk_i   (clk_75mhz),
    .rst_i   (rst_sync),
    .start_i (seq_start),
    .full_i  (seq_full),
    .step_i  (seq_step),
    .row_i   (seq_row),
    .row_o   (seq_row_nx),
    .col_o   (seq_col_nx),
    .last_o  (seq_last)
  );

  always_ff @(posedge clk_75mhz or posedge rst_sync) begin
    if (rst_sync) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wrap_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_print: begin
                state_q <= ST_WRITE;
                we_q    <= 1'b1;
                addr_q  <= {row_q, col_q};
                data_q  <= char_data;
                wrap_q  <= (col_q == COL_LAST);
                if (col_q == COL_LAST) begin
                  col_q <= '0;
                  row_q <= row_adv;
                end else begin
                  col_q <= col_q + 1'b1;
                end
              end
              is_cr: col_q <= '0;
              is_lf: begin
                col_q   <= '0;
                row_q   <= row_adv;
                state_q <= ST_ROW_CLR;
                we_q    <= 1'b1;
                addr_q  <= {seq_row_nx, seq_col_nx};
                data_q  <= CHAR_SPACE;
              end
              is_bs: begin
                if (col_q != '0) begin
                  col_q   <= col_q - 1'b1;
                  state_q <= ST_WRITE;
                  wrap_q  <= 1'b0;
                  we_q    <= 1'b1;
                  addr_q  <= {row_q, col_q - 1'b1};
                  data_q  <= CHAR_SPACE;
                end
              end
              is_ff: begin
                col_q   <= '0;
                row_q   <= '0;
                state_q <= ST_SCR_CLR;
                we_q    <= 1'b1;
                addr_q  <= {seq_row_nx, seq_col_nx};
                data_q  <= CHAR_SPACE;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          wrap_q <= 1'b0;
          if (wrap_q) begin
            state_q <= ST_ROW_CLR;
            we_q    <= 1'b1;
            addr_q  <= {seq_row_nx, seq_col_nx};
            data_q  <= CHAR_SPACE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          if (seq_last) begin
            state_q <= ST_IDLE;
          end else begin
            we_q   <= 1'b1;
            addr_q <= {seq_row_nx, seq_col_nx};
            data_q <= CHAR_SPACE;
          end
        end
      endcase
    end
  end

  assign char_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_data  = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_tile_text_writer.sv
// Randomized bench for tile_text_writer against a cursor/write-list model.
// Checks every BRAM write, cursor after each byte, and busy/ready cycle counts.
module tb_tile_text_writer;

  logic        clk_75mhz;
  logic        rst_sync;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        bram_we;
  logic [13:0] bram_addr;
  logic [7:0]  bram_data;
  logic [7:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // expected writes, {addr, data}
  logic [21:0] exp_q[$];
  int mr = 0;
  int mc = 0;
  int lat_exp = 0;

  tile_text_writer dut (
    .clk_75mhz  (clk_75mhz),
    .rst_sync   (rst_sync),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial begin
    clk_75mhz = 1'b0;
    forever #5 clk_75mhz = ~clk_75mhz;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void push_wr(input int r, input int c, input int d);
    exp_q.push_back({14'(r * 256 + c), 8'(d)});
  endfunction

  function automatic void adv_row();
    mr = (mr == 44) ? 0 : mr + 1;
    mc = 0;
    for (int c = 0; c < 160; c++) push_wr(mr, c, 32);
  endfunction

  function automatic void model(input int b);
    lat_exp = 0;
    if (b >= 32 && b <= 126) begin
      push_wr(mr, mc, b);
      lat_exp = 1;
      if (mc == 159) begin
        adv_row();
        lat_exp += 160;
      end else begin
        mc++;
      end
    end else if (b == 13) begin
      mc = 0;
    end else if (b == 10) begin
      adv_row();
      lat_exp = 160;
    end else if (b == 8) begin
      if (mc > 0) begin
        mc--;
        push_wr(mr, mc, 32);
        lat_exp = 1;
      end
    end else if (b == 12) begin
      for (int r = 0; r < 45; r++)
        for (int c = 0; c < 160; c++) push_wr(r, c, 32);
      mr = 0;
      mc = 0;
      lat_exp = 7200;
    end
  endfunction

  always @(negedge clk_75mhz) begin
    if (!rst_sync && bram_we) begin
      if (exp_q.size() == 0) begin
        chk("wr_extra", exp_q.size(), 1);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", bram_addr, e[21:8]);
        chk("wr_data", bram_data, e[7:0]);
        chk("wr_col_range", int'(bram_addr[7:0] < 8'd160), 1);
      end
    end
  end

  task automatic wait_ready();
    int n;
    int nb;
    n = 0;
    nb = 0;
    while (!char_ready && n < 8000) begin
      if (busy) nb++;
      @(negedge clk_75mhz);
      n++;
    end
    chk("ready_lat", n, lat_exp);
    chk("busy_len", nb, lat_exp);
    if (!char_ready) begin
      $display("FAIL ready_timeout: got 0 want 1");
      $fatal(1);
    end
  endtask

  // holds the next byte on char_valid while the writer is still busy
  task automatic send(input logic [7:0] b);
    char_valid = 1'b1;
    char_data  = b;
    wait_ready();
    @(posedge clk_75mhz);
    model(int'(b));
    @(negedge clk_75mhz);
    char_valid = 1'b0;
    chk("cur_col", cursor_col, mc);
    chk("cur_row", cursor_row, mr);
  endtask

  function automatic logic [7:0] pick();
    int r;
    int v;
    r = $urandom_range(0, 99);
    if (r < 55) return 8'($urandom_range(32, 126));
    if (r < 63) return 8'h0A;
    if (r < 71) return 8'h0D;
    if (r < 85) return 8'h08;
    v = $urandom_range(0, 255);
    return (v == 12) ? 8'h00 : 8'(v);
  endfunction

  initial begin
    rst_sync   = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (3) @(negedge clk_75mhz);
    rst_sync = 1'b0;
    @(negedge clk_75mhz);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_data", bram_data, 0);
    chk("rst_ready", char_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);

    send(8'h41);
    send(8'h42);
    send(8'h0D);
    for (int i = 0; i < 160; i++) send(8'h58);
    send(8'h08);
    send(8'h41);
    send(8'h42);
    send(8'h08);
    for (int i = 0; i < 45; i++) send(8'h0A);
    for (int i = 0; i < 250; i++) send(pick());
    send(8'h0C);
    for (int i = 0; i < 40; i++) send(pick());

    send(8'h0C);
    repeat (100) @(posedge clk_75mhz);
    #2;
    rst_sync = 1'b1;
    exp_q.delete();
    mr = 0;
    mc = 0;
    lat_exp = 0;
    #1;
    chk("abort_we", bram_we, 0);
    chk("abort_col", cursor_col, 0);
    chk("abort_row", cursor_row, 0);
    @(negedge clk_75mhz);
    rst_sync = 1'b0;
    @(negedge clk_75mhz);
    chk("abort_ready", char_ready, 1);

    for (int i = 0; i < 100; i++) send(pick());
    wait_ready();
    repeat (2) @(negedge clk_75mhz);
    chk("wr_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
